// File: rtl/sigmux_pkg.sv
// Shared definitions for the output time-division multiplexer.
// Holds the fixed word width and the elaboration-time sizing helpers.
package sigmux_pkg;

  localparam int WORD_W = 16;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Counter width for n states, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mux_slot_counter.sv
// Free-running slot counter: 0..N_slots-1, wraps to 0.
// is_first flags slot 0, which is the frame-capture slot.
module mux_slot_counter
  import sigmux_pkg::*;
#(
  parameter int N_slots = 10,
  localparam int CNT_W  = clog2_min1(N_slots)
) (
  input  logic             clk,
  input  logic             reset,
  output logic [CNT_W-1:0] slot_cnt,
  output logic             is_first
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_cnt <= '0;
    end else if (slot_cnt == CNT_W'(N_slots - 1)) begin
      slot_cnt <= '0;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  assign is_first = (slot_cnt == '0);

endmodule

// File: rtl/signal_multiplexer.sv
// Serialises N_signals words onto N_pins lanes over N_slots cycles per frame.
// Slot 0 snapshots the whole input bus so every frame is coherent.
module signal_multiplexer
  import sigmux_pkg::*;
#(
  parameter int N_signals = 40,
  parameter int N_pins    = 4,
  parameter int N_slots   = ceil_div(N_signals, N_pins),
  localparam int W        = WORD_W,
  localparam int IDX_W    = clog2_min1(N_slots)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [W*N_signals-1:0] signals,
  output logic [W*N_pins-1:0]    mux_out,
  output logic [IDX_W-1:0]       slot_idx,
  output logic                   frame_start
);

  logic [IDX_W-1:0]       slot_cnt;
  logic                   is_first;
  logic [W*N_signals-1:0] frame_buf;
  logic [W*N_signals-1:0] src;
  logic [W-1:0]           words [N_signals];
  logic [W*N_pins-1:0]    mux_nxt;

  mux_slot_counter #(
    .N_slots (N_slots)
  ) u_slot_counter (
    .clk      (clk),
    .reset    (reset),
    .slot_cnt (slot_cnt),
    .is_first (is_first)
  );

  // Slot 0 forwards the live bus so captured words leave on the same edge.
  assign src = is_first ? signals : frame_buf;

  always_comb begin
    for (int k = 0; k < N_signals; k++) begin
      words[k] = src[k*W +: W];
    end
  end

  for (genvar p = 0; p < N_pins; p++) begin : g_lane
    int         lane_idx;
    logic [W-1:0] lane_word;

    assign lane_idx = int'(slot_cnt) * N_pins + p;

    // Indices past the last word fall through to zero padding.
    always_comb begin
      lane_word = '0;
      for (int k = 0; k < N_signals; k++) begin
        if (k == lane_idx) lane_word = words[k];
      end
    end

    assign mux_nxt[p*W +: W] = lane_word;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_buf   <= '0;
      mux_out     <= '0;
      slot_idx    <= '0;
      frame_start <= 1'b0;
    end else begin
      if (is_first) frame_buf <= signals;
      mux_out     <= mux_nxt;
      slot_idx    <= slot_cnt;
      frame_start <= is_first;
    end
  end

endmodule

// File: tb/tb_signal_multiplexer.sv
// Directed bench: default frame, coherence, async reset, padding,
// single-slot and truncation configurations, each on its own instance.
module tb_signal_multiplexer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // d0: default 40/4/10
  logic          r0;
  logic [639:0]  sig0;
  logic [63:0]   out0;
  logic [3:0]    idx0;
  logic          fs0;
  // d1: padding 10/4/3
  logic          r1;
  logic [159:0]  sig1;
  logic [63:0]   out1;
  logic [1:0]    idx1;
  logic          fs1;
  // d2: single slot 4/4/1
  logic          r2;
  logic [63:0]   sig2;
  logic [63:0]   out2;
  logic [0:0]    idx2;
  logic          fs2;
  // d3: truncation 10/4/2
  logic          r3;
  logic [159:0]  sig3;
  logic [63:0]   out3;
  logic [0:0]    idx3;
  logic          fs3;

  signal_multiplexer #(.N_signals(40), .N_pins(4), .N_slots(10)) d0 (
    .clk(clk), .reset(r0), .signals(sig0), .mux_out(out0), .slot_idx(idx0), .frame_start(fs0));
  signal_multiplexer #(.N_signals(10), .N_pins(4), .N_slots(3)) d1 (
    .clk(clk), .reset(r1), .signals(sig1), .mux_out(out1), .slot_idx(idx1), .frame_start(fs1));
  signal_multiplexer #(.N_signals(4), .N_pins(4), .N_slots(1)) d2 (
    .clk(clk), .reset(r2), .signals(sig2), .mux_out(out2), .slot_idx(idx2), .frame_start(fs2));
  signal_multiplexer #(.N_signals(10), .N_pins(4), .N_slots(2)) d3 (
    .clk(clk), .reset(r3), .signals(sig3), .mux_out(out3), .slot_idx(idx3), .frame_start(fs3));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Four consecutive words starting at base, lane 0 in the low bits.
  function automatic logic [63:0] lanes4(input logic [15:0] base);
    return {base + 16'd3, base + 16'd2, base + 16'd1, base};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] pat;
    logic [15:0] w;
    r0 = 1'b0; r1 = 1'b0; r2 = 1'b0; r3 = 1'b0;
    for (int k = 0; k < 40; k++) sig0[k*16 +: 16] = 16'h0100 + 16'(k);
    for (int k = 0; k < 10; k++) sig1[k*16 +: 16] = 16'(k + 1);
    for (int k = 0; k < 10; k++) sig3[k*16 +: 16] = 16'hA000 + 16'(k);
    sig2 = '0;

    step();
    step();
    check("rst_mux_out", out0, 64'h0);
    check("rst_slot_idx", 64'(idx0), 64'h0);
    check("rst_frame_start", 64'(fs0), 64'h0);

    // ---- default frame and coherence ----
    @(negedge clk);
    r0 = 1'b1;
    step();
    check("e1_mux_out", out0, 64'h0103_0102_0101_0100);
    check("e1_slot_idx", 64'(idx0), 64'h0);
    check("e1_frame_start", 64'(fs0), 64'h1);
    sig0 = {640{1'b1}};
    for (int s = 1; s < 10; s++) begin
      step();
      check($sformatf("slot%0d_mux_out", s), out0, lanes4(16'h0100 + 16'(4*s)));
      check($sformatf("slot%0d_slot_idx", s), 64'(idx0), 64'(s));
      check($sformatf("slot%0d_frame_start", s), 64'(fs0), 64'h0);
    end
    check("e10_mux_out", out0, 64'h0127_0126_0125_0124);
    step();
    check("e11_mux_out", out0, {64{1'b1}});
    check("e11_slot_idx", 64'(idx0), 64'h0);
    check("e11_frame_start", 64'(fs0), 64'h1);

    // ---- async reset at slot 5 ----
    for (int s = 1; s <= 5; s++) step();
    check("pre_rst_slot_idx", 64'(idx0), 64'h5);
    #2;
    r0 = 1'b0;
    #1;
    check("async_rst_mux_out", out0, 64'h0);
    check("async_rst_slot_idx", 64'(idx0), 64'h0);
    check("async_rst_frame_start", 64'(fs0), 64'h0);
    for (int k = 0; k < 40; k++) sig0[k*16 +: 16] = 16'h0200 + 16'(k);
    @(negedge clk);
    r0 = 1'b1;
    step();
    check("post_rst_mux_out", out0, 64'h0203_0202_0201_0200);
    check("post_rst_slot_idx", 64'(idx0), 64'h0);
    check("post_rst_frame_start", 64'(fs0), 64'h1);
    step();
    check("post_rst_slot1", out0, 64'h0207_0206_0205_0204);

    // ---- padding ----
    @(negedge clk);
    r1 = 1'b1;
    step();
    check("pad_slot0", out1, 64'h0004_0003_0002_0001);
    step();
    check("pad_slot1", out1, 64'h0008_0007_0006_0005);
    step();
    check("pad_slot2", out1, 64'h0000_0000_000A_0009);
    check("pad_slot2_idx", 64'(idx1), 64'h2);
    step();
    check("pad_wrap_fs", 64'(fs1), 64'h1);

    // ---- single slot: output follows input every edge ----
    @(negedge clk);
    r2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pat = {16'(16'h1111 * (i + 1)), 16'(16'h0F0F ^ i), 16'(16'hC000 + i), 16'(i * 7)};
      @(negedge clk);
      sig2 = pat;
      step();
      check($sformatf("n1_mux_out_%0d", i), out2, pat);
      check($sformatf("n1_slot_idx_%0d", i), 64'(idx2), 64'h0);
      check($sformatf("n1_frame_start_%0d", i), 64'(fs2), 64'h1);
    end

    // ---- truncation: words 8 and 9 never appear ----
    @(negedge clk);
    r3 = 1'b1;
    for (int e = 0; e < 6; e++) begin
      step();
      check($sformatf("trunc_e%0d_mux_out", e), out3, lanes4(16'hA000 + 16'(4 * (e % 2))));
      check($sformatf("trunc_e%0d_fs", e), 64'(fs3), 64'((e % 2) == 0));
      for (int p = 0; p < 4; p++) begin
        w = out3[p*16 +: 16];
        check($sformatf("trunc_e%0d_l%0d_hidden", e, p),
              64'((w == 16'hA008) || (w == 16'hA009)), 64'h0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/signal_multiplexer.md
Name: signal_multiplexer

Overview:
- Time-division multiplexer that serialises N_signals 16-bit words onto N_pins 16-bit output pins, N_pins words per clock, over N_slots consecutive slots per frame.
- Each frame is captured as one coherent snapshot of the input bus.
- Sits downstream of the compressed-sensing accumulator (M=40 signals -> 4 pins, 10 slots) and drives the chip's narrow output interface.

Parameters:
- N_signals, 40: number of 16-bit input words packed on `signals`.
- N_pins, 4: number of 16-bit output lanes on `mux_out`.
- N_slots, 10: slots per frame; nominally ceil(N_signals/N_pins); must be >= 1.
- W, 16: word width, fixed at 16. Exposed as a localparam only.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset; 0 = in reset.
- signals  in  16*N_signals  packed input words; word k = signals[16k+15:16k].
- mux_out  out  16*N_pins  packed output lanes; lane p = mux_out[16p+15:16p].
- slot_idx  out  clog2(N_slots) (min 1)  slot number that mux_out currently carries.
- frame_start  out  1  high while mux_out carries slot 0 of a new frame.

Behaviour:
- Reset (reset==0, async assert, sync release): slot_cnt=0, frame_buf=0, mux_out=0, slot_idx=0, frame_start=0.
- Internal state:
  - slot_cnt counts 0..N_slots-1 and wraps to 0.
  - frame_buf is a 16*N_signals snapshot register.
- Every rising clk edge out of reset:
  - src = (slot_cnt==0) ? signals : frame_buf.
  - If slot_cnt==0: frame_buf <= signals (frame capture).
  - For each lane p: idx = slot_cnt*N_pins + p.
    - idx < N_signals: mux_out lane p <= word idx of src.
    - idx >= N_signals: lane p <= 16'h0000 (padding).
  - slot_idx <= slot_cnt; frame_start <= (slot_cnt==0).
  - slot_cnt <= (slot_cnt==N_slots-1) ? 0 : slot_cnt+1.
- Latency:
  - All outputs are registered. Words sampled at the capture edge appear on mux_out at that same edge, for slot 0.
  - Slot s of that frame appears s cycles later.
- Input changes between capture edges do not affect the frame in flight. They are picked up at the next slot-0 edge.
- Frame period is N_slots cycles. The first post-reset edge is a capture edge.
- N_slots==1: capture occurs every cycle; frame_start is held at 1 after the first edge.
- N_slots*N_pins < N_signals: words with idx >= N_slots*N_pins are never transmitted. This is legal, no error.
- N_slots*N_pins > N_signals: trailing lanes and slots are zero-padded.
- Reset asserted mid-frame: all outputs clear immediately (async). After release, the next edge starts a fresh frame at slot 0.
- No handshake; the consumer aligns on frame_start/slot_idx.
- Index arithmetic uses at least 32-bit integers, so no overflow for legal parameters.

Decomposition:
- Shared package `sigmux_pkg`:
  - localparam WORD_W=16.
  - function ceil_div(a,b) for the default N_slots.
  - function clog2_min1.
- One sub-module, `mux_slot_counter`:
  - Parameter N_slots; wrapping counter with async active-low reset.
  - Outputs slot_cnt and is_first (slot_cnt==0).
- Lane selection and padding stay in signal_multiplexer as a generate loop over N_pins.

Test Plan:
- Default params, word k = 16'h0100+k, release reset:
  - Edge 1: mux_out = {0x0103,0x0102,0x0101,0x0100}, slot_idx=0, frame_start=1.
  - Edge 10: {0x0127..0x0124}, slot_idx=9.
  - Edge 11: slot 0 again, frame_start=1.
- Coherence, default params:
  - Change all inputs to 16'hFFFF on the cycle after capture.
  - Slots 1..9 still output 0x01xx values.
  - The next frame outputs all 0xFFFF.
- Padding, N_signals=10, N_pins=4, N_slots=3, word k = k+1:
  - Slot 2 outputs lanes {0,0,10,9}, i.e. lane0=9, lane1=10, lanes 2..3=0.
- Async reset at slot 5 of a default frame:
  - Outputs go 0 with no clk edge.
  - After release, first edge gives slot_idx=0, frame_start=1, freshly captured data.
- N_slots=1, N_signals=4, N_pins=4:
  - Inputs change every cycle; mux_out tracks inputs each edge.
  - frame_start stays 1; slot_idx stays 0.
- Truncation, N_signals=10, N_pins=4, N_slots=2:
  - Words 8..9 are never seen on any lane across 3 frames.
